// File: rtl/n2r_pkg.sv
// Shared types and derived geometry for the normal-to-ready reshaping scheduler.
// All geometry helpers are constant functions of the top-level parameters.
package n2r_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } top_state_t;

  function automatic int group_rows(input int block_size, input int num_cores);
    return block_size * num_cores;
  endfunction

  function automatic int num_slices(input int block_size, input int col);
    return col / block_size;
  endfunction

  function automatic int num_groups(input int row, input int grp_rows);
    return (row + grp_rows - 1) / grp_rows;
  endfunction

  function automatic int last_rows(input int row, input int grp_rows);
    return row - (num_groups(row, grp_rows) - 1) * grp_rows;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/n2r_bank_tracker.sv
// Ping-pong bank bookkeeping: per-bank EMPTY/FILL/FULL state, fill/drain pointers
// and the row count captured when each group closes. Updates land one cycle after the event.
module n2r_bank_tracker
  import n2r_pkg::*;
#(
  parameter  int GROUP_ROWS = 4,
  localparam int CW         = $clog2(GROUP_ROWS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr,
  input  logic          set_full,
  input  logic          rel,
  input  logic [CW-1:0] full_rows,
  output logic          fp,
  output logic          dp,
  output logic          fp_full,
  output logic          dp_full,
  output logic [CW-1:0] dp_rows
);

  bank_state_t   st  [2];
  logic [CW-1:0] cnt [2];

  // set_full and rel never target the same bank: fill only closes a non-FULL bank,
  // drain only releases a FULL one, so both may apply in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fp <= 1'b0;
      dp <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        st[b]  <= EMPTY;
        cnt[b] <= CW'(GROUP_ROWS);
      end
    end else if (clear) begin
      fp <= 1'b0;
      dp <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        st[b] <= EMPTY;
      end
    end else begin
      if (set_full) begin
        st[fp]  <= FULL;
        cnt[fp] <= full_rows;
        fp      <= ~fp;
      end else if (wr && st[fp] == EMPTY) begin
        st[fp] <= FILL;
      end
      if (rel) begin
        st[dp] <= EMPTY;
        dp     <= ~dp;
      end
    end
  end

  assign fp_full = (st[fp] == FULL);
  assign dp_full = (st[dp] == FULL);
  assign dp_rows = cnt[dp];

endmodule

// File: rtl/n2r_sched.sv
// Sequences row writes into ping-pong group banks and per-group slice reads; first slice 1 cycle after a group closes.
// Upstream stalls (in_ready=0) while the fill bank is still FULL; slice commands hold while out_ready is low.
module n2r_sched
  import n2r_pkg::*;
#(
  parameter  int BLOCK_SIZE = 2,
  parameter  int NUM_CORES  = 8,
  parameter  int ROW        = 2754,
  parameter  int COL        = 256,
  localparam int GR         = group_rows(BLOCK_SIZE, NUM_CORES),
  localparam int NS         = num_slices(BLOCK_SIZE, COL),
  localparam int NG         = num_groups(ROW, GR),
  localparam int WRW        = clog2w(GR),
  localparam int SLW        = clog2w(NS),
  localparam int RRW        = $clog2(GR + 1),
  localparam int RIW        = $clog2(ROW + 1),
  localparam int GOW        = $clog2(NG + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           wr_en,
  output logic           wr_bank,
  output logic [WRW-1:0] wr_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           rd_bank,
  output logic [SLW-1:0] rd_slice,
  output logic [RRW-1:0] rd_rows,
  output logic           out_last_slice,
  output logic           out_last_group,
  output logic           busy,
  output logic           done
);

  top_state_t     state;
  logic [RIW-1:0] rows_in;
  logic [GOW-1:0] groups_out;
  logic           fp, dp, fp_full, dp_full;
  logic [RRW-1:0] dp_rows;
  logic           run, job_start, close, hs, last_hs;

  assign run       = (state == RUN);
  assign job_start = (state == IDLE) & start;

  assign in_ready = run & ~fp_full & (rows_in < RIW'(ROW));
  assign wr_en    = in_valid & in_ready;
  assign wr_bank  = fp;
  // A group closes on its last physical row or on the job's final row (short last group).
  assign close    = wr_en & ((wr_row == WRW'(GR - 1)) | (rows_in == RIW'(ROW - 1)));

  assign hs      = out_valid & out_ready;
  assign last_hs = hs & (rd_slice == SLW'(NS - 1));

  assign rd_bank        = dp;
  assign rd_rows        = dp_rows;
  assign out_last_slice = out_valid & (rd_slice == SLW'(NS - 1));
  assign out_last_group = out_valid & (groups_out == GOW'(NG - 1));
  assign busy           = run;
  assign done           = (state == FIN);

  n2r_bank_tracker #(
    .GROUP_ROWS (GR)
  ) u_banks (
    .clk       (clk),
    .rst       (rst),
    .clear     (job_start),
    .wr        (wr_en),
    .set_full  (close),
    .rel       (last_hs),
    .full_rows (RRW'(wr_row) + RRW'(1)),
    .fp        (fp),
    .dp        (dp),
    .fp_full   (fp_full),
    .dp_full   (dp_full),
    .dp_rows   (dp_rows)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rows_in    <= '0;
      groups_out <= '0;
      wr_row     <= '0;
      rd_slice   <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            rows_in    <= '0;
            groups_out <= '0;
            wr_row     <= '0;
            rd_slice   <= '0;
            out_valid  <= 1'b0;
          end
        end
        RUN: begin
          if (wr_en) begin
            rows_in <= rows_in + RIW'(1);
            wr_row  <= close ? '0 : wr_row + WRW'(1);
          end
          // After a release out_valid is low for one cycle, then re-evaluates the next bank.
          if (hs) begin
            if (last_hs) begin
              rd_slice   <= '0;
              out_valid  <= 1'b0;
              groups_out <= groups_out + GOW'(1);
              if (groups_out == GOW'(NG - 1)) begin
                state <= FIN;
              end
            end else begin
              rd_slice <= rd_slice + SLW'(1);
            end
          end else if (!out_valid) begin
            out_valid <= dp_full | (close & (fp == dp));
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n2r_sched.sv
// Bench for n2r_sched at BLOCK_SIZE=2, NUM_CORES=2, ROW=10, COL=8 (4-row groups, 4 slices, 3 groups, last group 2 rows).
module tb_n2r_sched;

  localparam int ROW = 10;
  localparam int GR  = 4;
  localparam int NS  = 4;
  localparam int NG  = 3;
  localparam int LR  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid, out_ready;
  logic       in_ready, wr_en, wr_bank;
  logic [1:0] wr_row;
  logic       out_valid, rd_bank;
  logic [1:0] rd_slice;
  logic [2:0] rd_rows;
  logic       out_last_slice, out_last_group, busy, done;

  n2r_sched #(
    .BLOCK_SIZE (2),
    .NUM_CORES  (2),
    .ROW        (10),
    .COL        (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_row         (wr_row),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .rd_bank        (rd_bank),
    .rd_slice       (rd_slice),
    .rd_rows        (rd_rows),
    .out_last_slice (out_last_slice),
    .out_last_group (out_last_group),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: job progress in rows written, groups closed, groups drained.
  int m_st;        // 0 idle, 1 run, 2 fin
  int m_rows, m_closed, m_drained, m_slice;
  bit m_gap;
  int n_wr, n_hs, n_done;
  bit e_ir, e_wr, e_ov;
  bit c_s, c_iv, c_or;

  typedef struct {
    bit s, iv, ordy;
    bit e_ir, e_wr;
    int e_wrow;
    bit e_ov;
    int e_slice;
    bit e_ls, e_busy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_rows = 0; m_closed = 0; m_drained = 0; m_slice = 0; m_gap = 0;
    n_wr = 0; n_hs = 0; n_done = 0;
  endtask

  task automatic sample();
    int g, d;
    bit run;
    run  = (m_st == 1);
    g    = m_rows / GR;
    d    = m_drained;
    e_ir = run && (m_rows < ROW) && (g < 2 || d >= g - 1);
    e_wr = c_iv && e_ir;
    e_ov = run && !m_gap && (m_closed > d);
    chk("in_ready", in_ready, e_ir);
    chk("wr_en", wr_en, e_wr);
    if (e_wr) begin
      chk("wr_bank", wr_bank, g % 2);
      chk("wr_row", wr_row, m_rows % GR);
    end
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      chk("rd_bank", rd_bank, d % 2);
      chk("rd_slice", rd_slice, m_slice);
      chk("rd_rows", rd_rows, (d == NG - 1) ? LR : GR);
      chk("out_last_slice", out_last_slice, m_slice == NS - 1);
      chk("out_last_group", out_last_group, d == NG - 1);
    end
    chk("busy", busy, run);
    chk("done", done, m_st == 2);
    if (wr_en === 1'b1) n_wr++;
    if (out_valid === 1'b1 && c_or) n_hs++;
    if (done === 1'b1) n_done++;
  endtask

  task automatic update();
    case (m_st)
      0: if (c_s) begin
        m_st = 1; m_rows = 0; m_closed = 0; m_drained = 0; m_slice = 0; m_gap = 0;
        n_wr = 0; n_hs = 0; n_done = 0;
      end
      1: begin
        if (e_wr) begin
          m_rows++;
          if (m_rows % GR == 0 || m_rows == ROW) m_closed++;
        end
        m_gap = 0;
        if (e_ov && c_or) begin
          if (m_slice == NS - 1) begin
            m_slice = 0;
            m_drained++;
            m_gap = 1;
            if (m_drained == NG) m_st = 2;
          end else begin
            m_slice++;
          end
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic drive_sample(input bit s, input bit iv, input bit ordy);
    start = s; in_valid = iv; out_ready = ordy;
    c_s = s; c_iv = iv; c_or = ordy;
    @(negedge clk);
    sample();
  endtask

  task automatic advance();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic step(input bit s, input bit iv, input bit ordy);
    drive_sample(s, iv, ordy);
    advance();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_wr_row"}, wr_row, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_rd_bank"}, rd_bank, 0);
    chk({tag, "_rd_slice"}, rd_slice, 0);
    chk({tag, "_rd_rows"}, rd_rows, GR);
    chk({tag, "_last_slice"}, out_last_slice, 0);
    chk({tag, "_last_group"}, out_last_group, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_job(input string tag, input int ps, input int piv, input int por);
    int k;
    step(1'b1, 1'b0, 1'b0);
    k = 0;
    while (m_st != 0 && k < 800) begin
      step($urandom_range(0, 99) < ps, $urandom_range(0, 99) < piv, $urandom_range(0, 99) < por);
      k++;
    end
    chk({tag, "_finished"}, m_st == 0, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_rows"}, n_wr, ROW);
    chk({tag, "_slices"}, n_hs, NG * NS);
    chk({tag, "_done_pulses"}, n_done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // s, iv, ordy | in_ready, wr_en, wr_row, out_valid, rd_slice, last_slice, busy
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 0, 1, 1, 1, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 1, 1, 2, 0, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 1, 1, 3, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1};
    tbl[7]  = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 1, 0, 0, 1, 2, 0, 1};
    tbl[9]  = '{0, 0, 1, 1, 0, 0, 1, 2, 0, 1};
    tbl[10] = '{0, 0, 1, 1, 0, 0, 1, 3, 1, 1};
    tbl[11] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

    model_reset();
    do_reset("reset");

    // Idle with in_valid high and no start: nothing accepted.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("idle_rd_rows", rd_rows, GR);
    end

    // Directed trace: first group fill, 1-cycle slice latency, toggled out_ready.
    do_reset("reset_tbl");
    for (int i = 0; i < 13; i++) begin
      drive_sample(tbl[i].s, tbl[i].iv, tbl[i].ordy);
      chk("tbl_in_ready", in_ready, tbl[i].e_ir);
      chk("tbl_wr_en", wr_en, tbl[i].e_wr);
      if (tbl[i].e_wr) chk("tbl_wr_row", wr_row, tbl[i].e_wrow);
      chk("tbl_out_valid", out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk("tbl_rd_slice", rd_slice, tbl[i].e_slice);
      chk("tbl_last_slice", out_last_slice, tbl[i].e_ls);
      chk("tbl_busy", busy, tbl[i].e_busy);
      advance();
    end

    // Full-throughput job.
    do_reset("reset_s2");
    run_job("full_rate", 0, 100, 100);

    // Drain stalled: both banks fill, then backpressure; release lets the job finish.
    do_reset("reset_s3");
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
    chk("stall_rows_accepted", n_wr, 8);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_rd_slice", rd_slice, 0);
    chk("stall_rd_bank", rd_bank, 0);
    k = 0;
    while (m_st != 0 && k < 200) begin
      step(1'b0, 1'b1, 1'b1);
      k++;
    end
    chk("stall_finished", m_st == 0, 1);
    chk("stall_rows", n_wr, ROW);
    chk("stall_done_pulses", n_done, 1);

    // Reset in the middle of group 1, slice 2: abandoned, then a clean job.
    do_reset("reset_s5");
    step(1'b1, 1'b0, 1'b0);
    k = 0;
    while (!(m_drained == 1 && m_slice == 2) && k < 100) begin
      step(1'b0, 1'b1, 1'b1);
      k++;
    end
    chk("midjob_rd_slice", rd_slice, 2);
    chk("midjob_rd_bank", rd_bank, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midjob_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("midjob_no_done", n_done, 0);
    run_job("after_rst", 0, 100, 100);

    // start pulses during RUN and FIN are ignored.
    run_job("start_spam", 50, 100, 100);
    run_job("start_always", 100, 100, 100);

    // Randomized traffic.
    for (int j = 0; j < 8; j++) begin
      run_job("random", 25, $urandom_range(30, 100), $urandom_range(30, 100));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n2r_sched.md
Name: n2r_sched

Overview:
- Controller that sequences the normal-to-ready reshaping datapath for one ROW x COL matrix.
- Accepts row beats from the upstream row stream and writes them into a ping-pong pair of row-group banks.
- Each row group holds BLOCK_SIZE*NUM_CORES rows. For each full group it issues COL/BLOCK_SIZE slice-read commands to the matrix-multiply feeder.
- Owns no data: it only drives bank/row/slice indices, handshakes and completion.

Parameters:
- BLOCK_SIZE, 2: rows/cols per systolic block.
- NUM_CORES, 8: parallel MAC cores fed per slice.
- ROW, 2754: matrix rows per job.
- COL, 256: matrix columns. Must be a multiple of BLOCK_SIZE.
- Derived constants:
  - GROUP_ROWS = BLOCK_SIZE*NUM_CORES
  - NUM_SLICES = COL/BLOCK_SIZE
  - NUM_GROUPS = ceil(ROW/GROUP_ROWS)
  - LAST_ROWS = ROW - (NUM_GROUPS-1)*GROUP_ROWS

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job start pulse.
- in_valid  in  1  upstream row beat valid.
- in_ready  out  1  scheduler can accept a row this cycle.
- wr_en  out  1  write current row into bank wr_bank at wr_row.
- wr_bank  out  1  bank being filled.
- wr_row  out  clog2(GROUP_ROWS)  row index within group.
- out_valid  out  1  slice command valid.
- out_ready  in  1  downstream accepts slice.
- rd_bank  out  1  bank being drained.
- rd_slice  out  clog2(NUM_SLICES)  slice (column-block) index.
- rd_rows  out  clog2(GROUP_ROWS+1)  valid rows in drained group. The datapath zero-pads rows at or beyond this count.
- out_last_slice  out  1  rd_slice == NUM_SLICES-1.
- out_last_group  out  1  drained group is group NUM_GROUPS-1.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse after the final slice handshake.

Behaviour:

Reset:
- Async on rst high. All counters are 0, both banks EMPTY, top state IDLE.
- Every output is 0 except rd_rows, which resets to GROUP_ROWS.
- A reset mid-job abandons the job with no done pulse.

Top FSM (IDLE -> RUN -> FIN -> IDLE):
- IDLE -> RUN on start. busy=1 in RUN.
- start while in RUN or FIN is ignored.
- RUN -> FIN on the handshake of the last slice of the last group.
- FIN lasts one cycle with done=1, busy=0, then returns to IDLE.

Bank states:
- Each bank has a registered state: EMPTY, FILL, FULL.
- Fill pointer fp and drain pointer dp both reset to 0.

Fill side:
- in_ready = RUN & bank[fp]!=FULL & rows_in<ROW.
- wr_en = in_valid & in_ready, combinational. wr_bank=fp.
- Each write increments wr_row and rows_in.
- A write with wr_row==GROUP_ROWS-1, or with rows_in==ROW-1, closes the group:
  - bank[fp] becomes FULL, the group's row count is stored, wr_row returns to 0, fp toggles.
- in_ready stays low while bank[fp] is FULL. This is backpressure when both banks are full.

Drain side:
- out_valid is registered. It rises the cycle after bank[dp] becomes FULL.
- First-slice latency is 1 cycle after the closing write.
- On out_valid & out_ready, rd_slice increments.
- On the handshake with rd_slice==NUM_SLICES-1:
  - bank[dp] becomes EMPTY, dp toggles, groups_out increments.
  - out_valid drops for at least one cycle, then re-evaluates the new bank[dp].
- out_valid, rd_slice, rd_bank and rd_rows hold stable while out_valid & ~out_ready.

Simultaneous events:
- A bank freed by drain in cycle N is writable from cycle N+1. This one-cycle bubble is intended.
- A fill close and a drain release on different banks in the same cycle are both applied.

Partial last group:
- When ROW % GROUP_ROWS != 0, the last group closes after LAST_ROWS writes and rd_rows=LAST_ROWS.
- Otherwise rd_rows=GROUP_ROWS.

Width rules:
- rows_in is clog2(ROW+1) bits and groups_out is clog2(NUM_GROUPS+1) bits.
- Counters never wrap within a job.
- Excess in_valid beats after ROW rows are not accepted (in_ready=0).

Decomposition:
- Package n2r_pkg holds:
  - GROUP_ROWS, NUM_SLICES, NUM_GROUPS, LAST_ROWS as functions of the parameters;
  - the bank_state_t enum (EMPTY/FILL/FULL);
  - the top_state_t enum (IDLE/RUN/FIN).
- One natural sub-module: n2r_bank_tracker. It holds the two bank states, fp/dp and the per-bank row counts, with set_full/release inputs.

Test Plan (BLOCK_SIZE=2, NUM_CORES=2, ROW=10, COL=8 -> GROUP_ROWS=4, NUM_SLICES=4, NUM_GROUPS=3, LAST_ROWS=2):
1. Reset then idle; in_valid=1 without start -> in_ready=0, wr_en=0, out_valid=0, rd_rows=4 for 20 cycles.
2. start, in_valid=1 and out_ready=1 continuously -> wr_row sequence 0,1,2,3 (bank0), 0,1,2,3 (bank1), 0,1 (bank0).
   - Slices 0..3 are issued per group with rd_rows 4,4,2.
   - out_last_group is high only in group 2.
   - done pulses exactly once, the cycle after the 12th handshake.
3. out_ready=0 throughout -> exactly 8 rows are accepted, then in_ready=0. out_valid is held with rd_slice=0, rd_bank=0.
   - Releasing out_ready lets the 9th write land in bank0 one cycle after group 0's last handshake.
4. Closing write in cycle N -> out_valid=1 in cycle N+1 with rd_slice=0.
   - out_ready toggled 1/0 -> rd_slice advances only on handshake cycles.
5. Assert rst mid-group 1 (slice 2) -> all outputs 0 and rd_rows=4 immediately, no done pulse.
   - A subsequent start runs a full clean job as in scenario 2.
6. start pulsed during RUN and during FIN -> ignored. Row/slice sequences and the single done pulse are unchanged.
